beatmap_sequencer: RTL

- Plays one level: steps through the beatmap ROM (3-bit address, 8-bit lane mask per beat) at a fixed beat rate.
- Presents each beat's note lanes to the note-drawing and hit-detection logic, with a one-cycle strobe per beat.
- Sits between the game FSM (start/pause/stop) and the combinational beatmap ROM, and owns the ROM address.

---
 rtl/beatmap_sequencer_pkg.sv | 17 +
 rtl/beatmap_sequencer_if.sv | 34 +++
 rtl/beatmap_sequencer_tick_gen.sv | 35 +++
 rtl/beatmap_sequencer.sv | 104 ++++++++++
 4 files changed

// File: rtl/beatmap_sequencer_pkg.sv
// Shared types and defaults for the beatmap sequencer: the FSM state enum,
// default geometry/rate parameters and the lane-mask type.
package rr_beat_pkg;

  localparam int ADDR_W_DEF         = 3;
  localparam int NOTE_W_DEF         = 8;
  localparam int TICKS_PER_BEAT_DEF = 25000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [NOTE_W_DEF-1:0] lane_mask_t;

endpackage

// File: rtl/beatmap_sequencer_if.sv
// Bus between the sequencer and its environment: game FSM controls, the
// beatmap ROM address/data pair, note outputs, status and a state view.
//
// Handshake: start/stop are single-cycle pulses and pause is a level, all
// sampled on the rising clock edge; note_valid is a one-cycle strobe that
// marks the cycle in which notes took a new value. There is no back-pressure.
interface beatmap_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int NOTE_W = 8
);
  import rr_beat_pkg::*;

  logic              start;
  logic              pause;
  logic              stop;
  logic [ADDR_W-1:0] rom_addr;
  logic [NOTE_W-1:0] rom_data;
  logic [NOTE_W-1:0] notes;
  logic              note_valid;
  logic              busy;
  logic              done;
  state_t            state;

  modport master (
    input  start, pause, stop, rom_data,
    output rom_addr, notes, note_valid, busy, done, state
  );

  modport slave (
    output start, pause, stop, rom_data,
    input  rom_addr, notes, note_valid, busy, done, state
  );

endinterface

// File: rtl/beatmap_sequencer_tick_gen.sv
// beat_tick_gen: pausable beat-rate counter. Counts 0..TICKS_PER_BEAT-1 while
// enabled and unpaused, and raises tick for the one cycle the count sits at
// its terminal value. clear forces the count to zero and suppresses the tick.
module beat_tick_gen #(
  parameter int TICKS_PER_BEAT = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic pause,
  output logic tick
);

  localparam int CNT_W = $clog2(TICKS_PER_BEAT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_BEAT - 1);

  logic [CNT_W-1:0] count;
  logic             advance;

  assign advance = enable && !pause && !clear;
  assign tick    = advance && (count == LAST);

  // Count register: cleared, held while paused, wraps to zero after the last tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (advance) begin
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/beatmap_sequencer.sv
// beatmap_sequencer: plays one level by stepping the beatmap ROM address at a
// fixed beat rate and presenting each beat's lane mask with a one-cycle strobe.
// Optional build macro BEATMAP_LOOP_EN: after the last beat the address wraps
// to zero and playback continues until stop (DONE is never entered).
module beatmap_sequencer
  import rr_beat_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int NOTE_W         = NOTE_W_DEF,
  parameter int TICKS_PER_BEAT = TICKS_PER_BEAT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  beatmap_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] notes_q, notes_d;
  logic              nv_q, nv_d;
  logic              tick;
  logic              tick_clear;

  // The counter only runs in PLAY; stop has to win over a terminal count.
  assign tick_clear = bus.stop || (state != PLAY);

  beat_tick_gen #(
    .TICKS_PER_BEAT (TICKS_PER_BEAT)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (state == PLAY),
    .pause  (bus.pause),
    .tick   (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      notes_q <= '0;
      nv_q    <= 1'b0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      notes_q <= notes_d;
      nv_q    <= nv_d;
    end
  end

  // Next-state and next-datapath logic; stop overrides everything else.
  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    notes_d = notes_q;
    nv_d    = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      addr_d  = '0;
      notes_d = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d = PLAY;
            addr_d  = '0;
          end
        end
        PLAY: begin
          if (tick) begin
            notes_d = bus.rom_data;
            nv_d    = 1'b1;
            if (addr_q != ADDR_MAX) begin
              addr_d = addr_q + ADDR_W'(1);
            end else begin
`ifdef BEATMAP_LOOP_EN
              addr_d = '0;
`else
              state_d = DONE;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
          notes_d = '0;
        end
      endcase
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.notes      = notes_q;
  assign bus.note_valid = nv_q;
  assign bus.busy       = (state == PLAY);
  assign bus.done       = (state == DONE);
  assign bus.state      = state;

endmodule
